// File: rtl/img_addr_gen.sv
// ---------------------------------------------------------------------------
// img_addr_gen
//
// Data-memory address generator placed directly after the processor control
// unit. It keeps two pointers:
//   * an output-image write pointer (MAR), and
//   * a row/column read cursor over the input image.
// One of the two drives the single data-memory address port. The row base
// (row * IMG_W) is kept as a running sum, so no multiplier is needed.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high; overrides every other input
//   mar_inc     MAR <- MAR + 1 (wraps silently at 2^ADDR_WIDTH)
//   col_inc     column += COL_STEP; wraps to 0 and pulses row_end on overflow
//   row_inc     row += ROW_STEP; wraps to 0 and sets frame_done on overflow
//   col_zero    column <- 0 (takes priority over col_inc)
//   addr_sel    0: read cursor on dmem_addr, 1: MAR on dmem_addr
//   done_clr    clears frame_done (a coincident row overflow wins)
//   dmem_addr   data-memory address
//   mar         write pointer
//   col, row    read-cursor coordinates
//   row_end     one-cycle pulse after a column wrap
//   frame_done  sticky flag set by a row wrap
// ---------------------------------------------------------------------------
module img_addr_gen #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned IMG_W      = 256,
    parameter int unsigned IMG_H      = 256,
    parameter int unsigned COL_STEP   = 2,
    parameter int unsigned ROW_STEP   = 2,
    parameter int unsigned RD_BASE    = 0,
    parameter int unsigned WR_BASE    = 32'h8000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mar_inc,
    input  logic                  col_inc,
    input  logic                  row_inc,
    input  logic                  col_zero,
    input  logic                  addr_sel,
    input  logic                  done_clr,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [ADDR_WIDTH-1:0] mar,
    output logic [15:0]           col,
    output logic [15:0]           row,
    output logic                  row_end,
    output logic                  frame_done
);

    localparam logic [ADDR_WIDTH-1:0] WR_BASE_A  = ADDR_WIDTH'(WR_BASE);
    localparam logic [ADDR_WIDTH-1:0] RD_BASE_A  = ADDR_WIDTH'(RD_BASE);
    // Amount the row base moves per row_inc; truncation is harmless because
    // the final address is taken modulo 2^ADDR_WIDTH anyway.
    localparam logic [ADDR_WIDTH-1:0] ROW_BASE_STEP = ADDR_WIDTH'(ROW_STEP * IMG_W);

    logic [ADDR_WIDTH-1:0] mar_q, mar_d;
    logic [15:0]           col_q, col_d;
    logic [15:0]           row_q, row_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic                  row_end_q, row_end_d;
    logic                  frame_done_q, frame_done_d;

    // One extra bit so the candidate position cannot wrap before the
    // bounds check sees it.
    logic [16:0] col_sum;
    logic [16:0] row_sum;
    logic        col_wrap;
    logic        row_wrap;

    assign col_sum  = {1'b0, col_q} + 17'(COL_STEP);
    assign row_sum  = {1'b0, row_q} + 17'(ROW_STEP);
    assign col_wrap = !(32'(col_sum) < IMG_W);
    assign row_wrap = !(32'(row_sum) < IMG_H);

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        mar_d        = mar_q;
        col_d        = col_q;
        row_d        = row_q;
        row_base_d   = row_base_q;
        row_end_d    = 1'b0;
        frame_done_d = frame_done_q;

        if (mar_inc) begin
            mar_d = mar_q + ADDR_WIDTH'(1);
        end

        if (col_zero) begin
            col_d = '0;
        end else if (col_inc) begin
            if (col_wrap) begin
                col_d     = '0;
                row_end_d = 1'b1;
            end else begin
                col_d = col_sum[15:0];
            end
        end

        // Clear first so a coincident row overflow below re-sets the flag.
        if (done_clr) begin
            frame_done_d = 1'b0;
        end

        if (row_inc) begin
            if (row_wrap) begin
                row_d        = '0;
                row_base_d   = '0;
                frame_done_d = 1'b1;
            end else begin
                row_d      = row_sum[15:0];
                row_base_d = row_base_q + ROW_BASE_STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            mar_q        <= WR_BASE_A;
            col_q        <= '0;
            row_q        <= '0;
            row_base_q   <= '0;
            row_end_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            mar_q        <= mar_d;
            col_q        <= col_d;
            row_q        <= row_d;
            row_base_q   <= row_base_d;
            row_end_q    <= row_end_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Pure mux on registered state: addr_sel takes effect with no latency.
    assign dmem_addr  = addr_sel ? mar_q : (RD_BASE_A + row_base_q + ADDR_WIDTH'(col_q));
    assign mar        = mar_q;
    assign col        = col_q;
    assign row        = row_q;
    assign row_end    = row_end_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_img_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_img_addr_gen
//
// Directed bench for img_addr_gen with an 8x4 image, step 2 in both axes,
// read base 0x100 and write base 0x8000. A second instance with write base
// 0xFFFE exercises the MAR wrap to zero. Inputs change 1 time unit after a
// rising edge; outputs are checked at that same point, well away from the
// next edge.
// ---------------------------------------------------------------------------
module tb_img_addr_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        mar_inc, col_inc, row_inc, col_zero, addr_sel, done_clr;
    logic [15:0] dmem_addr, mar, col, row;
    logic        row_end, frame_done;

    // Second instance: only reset and mar_inc2 move.
    logic        mar_inc2;
    logic        addr_sel2;
    logic        idle2;
    logic [15:0] dmem_addr2, mar2, col2, row2;
    logic        row_end2, frame_done2;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    img_addr_gen #(
        .ADDR_WIDTH(16), .IMG_W(8), .IMG_H(4), .COL_STEP(2), .ROW_STEP(2),
        .RD_BASE(32'h100), .WR_BASE(32'h8000)
    ) dut (
        .clk(clk), .reset(reset), .mar_inc(mar_inc), .col_inc(col_inc),
        .row_inc(row_inc), .col_zero(col_zero), .addr_sel(addr_sel),
        .done_clr(done_clr), .dmem_addr(dmem_addr), .mar(mar), .col(col),
        .row(row), .row_end(row_end), .frame_done(frame_done)
    );

    img_addr_gen #(
        .ADDR_WIDTH(16), .IMG_W(8), .IMG_H(4), .COL_STEP(2), .ROW_STEP(2),
        .RD_BASE(32'h100), .WR_BASE(32'hFFFE)
    ) dut_wrap (
        .clk(clk), .reset(reset), .mar_inc(mar_inc2), .col_inc(idle2),
        .row_inc(idle2), .col_zero(idle2), .addr_sel(addr_sel2),
        .done_clr(idle2), .dmem_addr(dmem_addr2), .mar(mar2), .col(col2),
        .row(row2), .row_end(row_end2), .frame_done(frame_done2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        mar_inc  = 1'b0;
        col_inc  = 1'b0;
        row_inc  = 1'b0;
        col_zero = 1'b0;
        done_clr = 1'b0;
        mar_inc2 = 1'b0;
    endtask

    initial begin
        logic [15:0] sweep_col [4];
        logic [15:0] sweep_addr[4];
        logic        sweep_end [4];
        sweep_col  = '{16'd2, 16'd4, 16'd6, 16'd0};
        sweep_addr = '{16'h102, 16'h104, 16'h106, 16'h100};
        sweep_end  = '{1'b0, 1'b0, 1'b0, 1'b1};

        clear_strobes();
        addr_sel  = 1'b0;
        addr_sel2 = 1'b1;
        idle2     = 1'b0;

        // ---- Reset ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mar",        32'(mar),        32'h8000);
        check("rst_col",        32'(col),        32'd0);
        check("rst_row",        32'(row),        32'd0);
        check("rst_addr",       32'(dmem_addr),  32'h100);
        check("rst_row_end",    32'(row_end),    32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_mar2",       32'(mar2),       32'hFFFE);
        check("rst_cursor2",    32'({col2, row2}), 32'd0);
        check("rst_flags2",     32'({row_end2, frame_done2}), 32'd0);

        // ---- Column sweep: 2,4,6 then wrap to 0 with a row_end pulse ----
        for (int i = 0; i < 4; i++) begin
            col_inc = 1'b1;
            tick();
            col_inc = 1'b0;
            check($sformatf("sweep_col_%0d", i),     32'(col),       32'(sweep_col[i]));
            check($sformatf("sweep_addr_%0d", i),    32'(dmem_addr), 32'(sweep_addr[i]));
            check($sformatf("sweep_row_end_%0d", i), 32'(row_end),   32'(sweep_end[i]));
        end
        tick();
        check("row_end_drops", 32'(row_end), 32'd0);
        check("col_wrap_no_row", 32'(row), 32'd0);

        // ---- Row step with col_zero, from col = 4 ----
        col_inc = 1'b1;
        tick();
        tick();
        col_inc = 1'b0;
        check("col_at_4", 32'(col), 32'd4);
        row_inc  = 1'b1;
        col_zero = 1'b1;
        tick();
        clear_strobes();
        check("rowstep_row",  32'(row),       32'd2);
        check("rowstep_col",  32'(col),       32'd0);
        check("rowstep_addr", 32'(dmem_addr), 32'h110);
        check("rowstep_done", 32'(frame_done), 32'd0);

        row_inc = 1'b1;
        tick();
        row_inc = 1'b0;
        check("rowwrap_row",  32'(row),        32'd0);
        check("rowwrap_addr", 32'(dmem_addr),  32'h100);
        check("rowwrap_done", 32'(frame_done), 32'd1);

        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("done_hold_%0d", i), 32'(frame_done), 32'd1);
        end
        done_clr = 1'b1;
        tick();
        done_clr = 1'b0;
        check("done_cleared", 32'(frame_done), 32'd0);

        // ---- MAR increments shown through the address mux ----
        addr_sel = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            mar_inc = 1'b1;
            tick();
            mar_inc = 1'b0;
            check($sformatf("mar_addr_%0d", i), 32'(dmem_addr), 32'h8000 + 32'(i));
        end
        addr_sel = 1'b0;
        #1;
        check("sel_read_now", 32'(dmem_addr), 32'h100);
        addr_sel = 1'b1;
        #1;
        check("sel_mar_now", 32'(dmem_addr), 32'h8003);
        addr_sel = 1'b0;

        // ---- MAR wrap on the 0xFFFE instance ----
        mar_inc2 = 1'b1;
        tick();
        check("mar2_ffff", 32'(mar2), 32'hFFFF);
        tick();
        mar_inc2 = 1'b0;
        check("mar2_wrap", 32'(mar2),       32'h0000);
        check("mar2_addr", 32'(dmem_addr2), 32'h0000);

        // ---- col_zero beats col_inc at col = 4 ----
        col_inc = 1'b1;
        tick();
        tick();
        check("prio_col_4", 32'(col), 32'd4);
        col_zero = 1'b1;
        tick();
        clear_strobes();
        check("prio_col",     32'(col),     32'd0);
        check("prio_row_end", 32'(row_end), 32'd0);

        // ---- done_clr coincident with a row overflow: set wins ----
        row_inc = 1'b1;
        tick();
        check("coll_row_2", 32'(row), 32'd2);
        done_clr = 1'b1;
        tick();
        clear_strobes();
        check("coll_row",  32'(row),        32'd0);
        check("coll_done", 32'(frame_done), 32'd1);

        // ---- Build row=2, col=6, mar=0x8005, then reset under strobes ----
        row_inc = 1'b1;
        col_inc = 1'b1;
        mar_inc = 1'b1;
        tick();
        row_inc = 1'b0;
        check("multi_row", 32'(row), 32'd2);
        check("multi_col", 32'(col), 32'd2);
        check("multi_mar", 32'(mar), 32'h8004);
        tick();
        mar_inc = 1'b0;
        tick();
        col_inc = 1'b0;
        check("pre_rst_mar",  32'(mar),       32'h8005);
        check("pre_rst_addr", 32'(dmem_addr), 32'h116);

        reset   = 1'b1;
        col_inc = 1'b1;
        row_inc = 1'b1;
        mar_inc = 1'b1;
        tick();
        reset = 1'b0;
        clear_strobes();
        check("mid_rst_mar",        32'(mar),        32'h8000);
        check("mid_rst_col",        32'(col),        32'd0);
        check("mid_rst_row",        32'(row),        32'd0);
        check("mid_rst_addr",       32'(dmem_addr),  32'h100);
        check("mid_rst_row_end",    32'(row_end),    32'd0);
        check("mid_rst_frame_done", 32'(frame_done), 32'd0);
        check("mid_rst_mar2",       32'(mar2),       32'hFFFE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/img_addr_gen.md
# img_addr_gen

Data-memory address generator that sits directly downstream of the processor control unit. It consumes the unit's `mar_inc`, `col_inc`, `row_inc` and `col_zero` strobes. It maintains an output-image write pointer (MAR) and a row/column read cursor over the input image, and drives the single data-memory address port. Row base is tracked incrementally, so no multiplier is used.

## Interface
- `ADDR_WIDTH`, 16: data-memory address width.
- `IMG_W`, 256: input image width in pixels, ≥ 2.
- `IMG_H`, 256: input image height in rows, ≥ 2.
- `COL_STEP`, 2: column advance per `col_inc`, ≥ 1.
- `ROW_STEP`, 2: row advance per `row_inc`, ≥ 1.
- `RD_BASE`, 0: data-memory address of input pixel (0,0).
- `WR_BASE`, 'h8000: MAR value after reset.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `mar_inc` in 1: advance MAR by 1.
- `col_inc` in 1: advance column by `COL_STEP`.
- `row_inc` in 1: advance row by `ROW_STEP`.
- `col_zero` in 1: clear column.
- `addr_sel` in 1: 0 selects the read cursor, 1 selects MAR.
- `done_clr` in 1: clear `frame_done`.
- `dmem_addr` out `ADDR_WIDTH`: address to data memory.
- `mar` out `ADDR_WIDTH`: write pointer.
- `col` out 16: current column.
- `row` out 16: current row.
- `row_end` out 1: column cursor wrapped (1-cycle pulse).
- `frame_done` out 1: row cursor wrapped (sticky).

## Operation
- Registers: `mar`, `col`, `row`, `row_base` (= row·IMG_W), `row_end`, `frame_done`.
- **Reset:**
  - `mar` = `WR_BASE`.
  - `col`, `row`, `row_base` = 0.
  - `row_end`, `frame_done` = 0.
  - Reset overrides all other inputs in the same cycle.
- **MAR:** on `mar_inc`, `mar` ← `mar`+1, modulo 2^ADDR_WIDTH. Wrap from all-ones to 0 is silent.
- **Column update**, priority `col_zero` > `col_inc`:
  - `col_zero`: `col` ← 0.
  - Else if `col_inc` and `col`+COL_STEP < IMG_W: `col` ← `col`+COL_STEP.
  - Else if `col_inc` (overflow): `col` ← 0 and `row_end` pulses 1 for one cycle.
- **Row update:**
  - `row_inc` with `row`+ROW_STEP < IMG_H: `row` ← `row`+ROW_STEP and `row_base` ← `row_base`+ROW_STEP·IMG_W.
  - Overflow: `row` ← 0, `row_base` ← 0, `frame_done` ← 1.
- Row and column updates are independent, so `row_inc`+`col_zero` in the same cycle (the control unit's ROW INCREMENT state) applies both.
- A column overflow never advances the row; row motion is explicit via `row_inc` only.
- **`frame_done`:**
  - Stays 1 until `done_clr` or `reset`.
  - `done_clr` coincident with a row overflow leaves it 1 (set wins).
- **Address:** `dmem_addr` = `addr_sel` ? `mar` : (`RD_BASE`+`row_base`+`col`), truncated to ADDR_WIDTH.
- Multiple strobes in one cycle (`mar_inc`, `col_inc`, `row_inc`) all take effect.

## Timing
- All strobes are sampled on the rising edge. Updated counters are visible immediately after that edge.
- `dmem_addr` is combinational from registered state and `addr_sel`. The address is therefore valid in the cycle following the strobe, in time for the control unit's `dmem_read`/`dmem_write` issued one state later.
- `addr_sel` has zero latency: it is a pure mux.
- `row_end` asserts the cycle after the overflowing `col_inc` and deasserts one cycle later, unless another overflow occurs.
- Strobes are level-sampled. A strobe held high for N cycles yields N increments; the control unit guarantees 1-cycle pulses.
- Reset mid-frame: the next cycle shows the reset values regardless of pending strobes.

## Test plan
Bench parameters: IMG_W=8, IMG_H=4, COL_STEP=2, ROW_STEP=2, RD_BASE=0x100, WR_BASE=0x8000.

- **Reset:** assert `reset` for 1 cycle → `mar`=0x8000, `col`=`row`=0, `dmem_addr`=0x100, `row_end`=`frame_done`=0.
- **Column sweep:** 4 `col_inc` pulses → `col` 2,4,6,0. `row_end`=1 only in the cycle after the 4th pulse. `dmem_addr` reads 0x102, 0x104, 0x106, 0x100.
- **Row step:** `row_inc`+`col_zero` together with `col`=4 → `row`=2, `col`=0, `dmem_addr`=0x110.
  - A second `row_inc` → `row`=0, `dmem_addr`=0x100, `frame_done`=1.
  - `frame_done` holds for 10 idle cycles, then clears one cycle after `done_clr`.
- **MAR:** 3 `mar_inc` pulses with `addr_sel`=1 → `dmem_addr` 0x8001, 0x8002, 0x8003. Toggling `addr_sel`=0 in the same cycle shows the read address.
  - Force `mar`=0xFFFF via increments from a WR_BASE=0xFFFE build, then `mar_inc` → 0x0000.
- **Priority and collision:**
  - `col_zero`+`col_inc` at `col`=4 → `col`=0, `row_end`=0.
  - `done_clr`+overflowing `row_inc` in the same cycle → `frame_done`=1.
- **Reset mid-operation:** `row`=2, `col`=6, `mar`=0x8005, then `reset` coincident with `col_inc`, `row_inc` and `mar_inc` → all reset values next cycle.
